// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity arbiter.
//   state_t  : sequencer states (IDLE, SHIFT, REPORT)
//   rr_pick  : round-robin winner search over up to MAX_NREQ requesters
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int unsigned MAX_NREQ = 4;
    localparam int unsigned MAX_IDW  = 2;

    // Search starts one past the last grantee and wraps; first set bit wins.
    function automatic logic [MAX_IDW-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input logic [MAX_IDW-1:0]  last,
        input int unsigned         nreq
    );
        logic [MAX_IDW-1:0] win;
        logic [MAX_IDW-1:0] idx;
        logic               found;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_NREQ; k++) begin
            idx = MAX_IDW'((32'(last) + k) % nreq);
            if (!found && (k <= nreq) && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/parity_acc.sv
// Registered running XOR used as the shared parity datapath.
//   clk, reset : clock and asynchronous active-high reset
//   clr        : synchronous clear (start of a new word)
//   en         : fold bit_in into the running parity this cycle
//   bit_in     : serial data bit
//   parity     : running XOR of all bits folded since the last clear
module parity_acc (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic parity
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity <= 1'b0;
        end else if (clr) begin
            parity <= 1'b0;
        end else if (en) begin
            parity <= parity ^ bit_in;
        end
    end

endmodule

// File: rtl/serial_parity_arbiter.sv
// Round-robin arbiter in front of one serial even-parity checker.
// A winning requester's word is captured, shifted out LSB-first through
// the parity accumulator, and the verdict is reported with its ID.
//   clk, reset  : clock and asynchronous active-high reset
//   req         : per-requester request levels
//   data_in     : packed words, requester i at [i*WIDTH +: WIDTH]
//   gnt         : one-hot, one-cycle grant on capture
//   busy        : high whenever a transaction is in flight
//   serial_bit  : bit currently fed to the accumulator (0 outside SHIFT)
//   done        : one-cycle result strobe
//   result_id   : grantee ID, qualified by done
//   parity_err  : odd count of ones in the word, qualified by done
module serial_parity_arbiter
    import serial_parity_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  serial_bit,
    output logic                  done,
    output logic [IDW-1:0]        result_id,
    output logic                  parity_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [IDW-1:0]   cur_id;
    logic [IDW-1:0]   last_id;

    logic             any_req_c;
    logic [IDW-1:0]   win_c;
    logic [WIDTH-1:0] word_c;
    logic             acc_clr_c;
    logic             acc_en_c;
    logic             parity_c;

    // Winner selection and its data slice
    assign any_req_c = |req;
    assign win_c     = IDW'(rr_pick(MAX_NREQ'(req), MAX_IDW'(last_id), NREQ));
    assign word_c    = data_in[32'(win_c)*WIDTH +: WIDTH];

    // Accumulator control: clear on capture, fold one bit per SHIFT cycle
    assign acc_clr_c = (state == IDLE) && any_req_c;
    assign acc_en_c  = (state == SHIFT);

    parity_acc u_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr_c),
        .en     (acc_en_c),
        .bit_in (shreg[0]),
        .parity (parity_c)
    );

    // Arbiter / sequencer with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            cur_id     <= '0;
            last_id    <= IDW'(NREQ - 1);
            gnt        <= '0;
            busy       <= 1'b0;
            serial_bit <= 1'b0;
            done       <= 1'b0;
            result_id  <= '0;
            parity_err <= 1'b0;
        end else begin
            gnt        <= '0;
            done       <= 1'b0;
            result_id  <= '0;
            parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        shreg      <= word_c;
                        cnt        <= '0;
                        cur_id     <= win_c;
                        gnt        <= NREQ'(1'b1) << win_c;
                        busy       <= 1'b1;
                        serial_bit <= word_c[0];
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= shreg >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // Last bit folds in this edge; report includes it
                        serial_bit <= 1'b0;
                        done       <= 1'b1;
                        result_id  <= cur_id;
                        parity_err <= parity_c ^ shreg[0];
                        state      <= REPORT;
                    end else begin
                        serial_bit <= shreg[1];
                    end
                end
                REPORT: begin
                    last_id <= cur_id;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parity_arbiter.sv
// Scoreboard bench for serial_parity_arbiter (WIDTH=8, NREQ=2).
// A transaction-level model decides grants from the round-robin rule and
// schedules expected per-cycle outputs; a negedge monitor compares them.
module tb_serial_parity_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned IDW   = 1;
    localparam int unsigned DW    = NREQ * WIDTH;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [DW-1:0]   data_in;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            serial_bit;
    logic            done;
    logic [IDW-1:0]  result_id;
    logic            parity_err;

    serial_parity_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data_in    (data_in),
        .gnt        (gnt),
        .busy       (busy),
        .serial_bit (serial_bit),
        .done       (done),
        .result_id  (result_id),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    typedef struct {
        int e;
        int id;
        int perr;
    } res_t;

    res_t exp_q[$];
    int   exp_gnt[int];
    int   exp_ser[int];
    int   exp_busy[int];
    int   free_edge = 0;
    int   last = NREQ - 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", name, edge_cnt, act, expv);
        end
    endtask

    // Reference model: whenever the checker is free and someone requests,
    // the first requester after the last grantee wins and the whole
    // transaction's visible outputs are scheduled from that edge.
    always @(posedge clk) begin
        edge_cnt++;
        if (reset) begin
            exp_q.delete();
            exp_gnt.delete();
            exp_ser.delete();
            exp_busy.delete();
            free_edge = edge_cnt;
            last      = NREQ - 1;
        end else if (edge_cnt >= free_edge && req != '0) begin
            int w;
            logic [WIDTH-1:0] word;
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (last + k) % NREQ;
                if (w < 0 && req[idx]) w = idx;
            end
            word = data_in[w*WIDTH +: WIDTH];
            exp_gnt[edge_cnt] = 1 << w;
            for (int i = 0; i < WIDTH; i++) exp_ser[edge_cnt + i] = int'(word[i]);
            for (int i = 0; i <= WIDTH; i++) exp_busy[edge_cnt + i] = 1;
            exp_q.push_back('{e: edge_cnt + WIDTH, id: w, perr: $countones(word) % 2});
            free_edge = edge_cnt + WIDTH + 2;
            last      = w;
        end
    end

    // Monitor: compare every cycle against the scheduled expectations
    always @(negedge clk) begin
        if (!reset) begin
            int g;
            int s;
            int b;
            res_t r;
            g = exp_gnt.exists(edge_cnt)  ? exp_gnt[edge_cnt]  : 0;
            s = exp_ser.exists(edge_cnt)  ? exp_ser[edge_cnt]  : 0;
            b = exp_busy.exists(edge_cnt) ? exp_busy[edge_cnt] : 0;
            chk("gnt", int'(gnt), g);
            chk("serial_bit", int'(serial_bit), s);
            chk("busy", int'(busy), b);
            if (exp_q.size() > 0 && exp_q[0].e < edge_cnt) begin
                chk("missing_done", 0, 1);
                void'(exp_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() > 0 && exp_q[0].e == edge_cnt) begin
                    r = exp_q.pop_front();
                    chk("result_id", int'(result_id), r.id);
                    chk("parity_err", int'(parity_err), r.perr);
                end else begin
                    chk("spurious_done", 1, 0);
                end
            end else begin
                chk("result_id_quiet", int'(result_id), 0);
                chk("parity_err_quiet", int'(parity_err), 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [NREQ-1:0] m, input logic [WIDTH-1:0] d0,
                        input logic [WIDTH-1:0] d1, input int hold);
        @(negedge clk);
        #1;
        req     = m;
        data_in = {d1, d0};
        repeat (hold) @(negedge clk);
        #1;
        req = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_outputs", int'({gnt, busy, serial_bit, done, result_id, parity_err}), 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        data_in = '0;
        idle(2);
        chk("reset_outputs", int'({gnt, busy, serial_bit, done, result_id, parity_err}), 0);
        #1;
        reset = 1'b0;

        // Single pass, then single fail on requester 1
        send(2'b01, 8'hA5, 8'h00, 1);
        idle(12);
        send(2'b10, 8'h00, 8'h07, 1);
        idle(12);

        // Reset during SHIFT drops the transaction; next request is normal
        send(2'b01, 8'hA5, 8'h00, 1);
        idle(2);
        pulse_reset();
        idle(12);
        send(2'b01, 8'hA5, 8'h00, 1);
        idle(12);

        // Both requesting from reset: grants alternate 0,1,0
        pulse_reset();
        send(2'b11, 8'h3C, 8'h01, 30);
        idle(12);

        // Request dropped right after capture still completes
        send(2'b10, 8'h00, 8'h6B, 1);
        idle(12);

        // All-ones and all-zero words
        send(2'b01, 8'hFF, 8'h00, 1);
        idle(12);
        send(2'b10, 8'h55, 8'h00, 1);
        idle(12);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                #1;
                chk("reset_outputs", int'({gnt, busy, serial_bit, done, result_id, parity_err}), 0);
            end
            req     = NREQ'($urandom);
            data_in = DW'($urandom);
        end
        #1;
        reset = 1'b0;
        req   = '0;
        idle(15);
        chk("drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog edge=%0d actual=running required=finished", edge_cnt);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
